// File: rtl/wino_ewmm_acc.sv
// rtl/wino_ewmm_acc.sv - Winograd F(2x2,3x3) element-wise multiply-accumulate stage with double-buffered M tile output
// Optional WINO_ACC_SAT_EN: saturate every accumulate to the signed data_width range instead of wrapping.
module wino_ewmm_acc #(
  parameter int data_width = 20,
  parameter int in_width   = 8,
  parameter int ch_width   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ch_width-1:0]    num_ch,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*in_width-1:0] u_flat,
  input  logic [16*in_width-1:0] v_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [data_width-1:0]  dout0,
  output logic [data_width-1:0]  dout1,
  output logic [data_width-1:0]  dout2,
  output logic [data_width-1:0]  dout3,
  output logic [data_width-1:0]  dout4,
  output logic [data_width-1:0]  dout5,
  output logic [data_width-1:0]  dout6,
  output logic [data_width-1:0]  dout7,
  output logic [data_width-1:0]  dout8,
  output logic [data_width-1:0]  dout9,
  output logic [data_width-1:0]  dout10,
  output logic [data_width-1:0]  dout11,
  output logic [data_width-1:0]  dout12,
  output logic [data_width-1:0]  dout13,
  output logic [data_width-1:0]  dout14,
  output logic [data_width-1:0]  dout15
);

  localparam int DW = data_width;
  localparam int PW = 2 * in_width;
  localparam logic [ch_width-1:0] CH_ONE = ch_width'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [ch_width-1:0]   cnt_q, cnt_d;
  logic [ch_width-1:0]   len_q, len_d;
  logic [DW-1:0]         acc_q  [16];
  logic [DW-1:0]         acc_d  [16];
  logic [DW-1:0]         dout_q [16];
  logic [DW-1:0]         dout_d [16];
  logic                  out_valid_q, out_valid_d;

  logic signed [PW-1:0]  prod  [16];
  logic [DW-1:0]         p_ext [16];
  logic [DW-1:0]         sum   [16];
  logic                  first_beat, fire, final_beat, out_hs;
  logic [ch_width-1:0]   len_eff, cnt_cur;

  function automatic logic [DW-1:0] acc_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef WINO_ACC_SAT_EN
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1])
      acc_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      acc_add = s[DW-1:0];
`else
    acc_add = a + b;
`endif
  endfunction

  assign in_ready   = (state_q != S_HOLD);
  assign out_valid  = out_valid_q;
  assign fire       = in_valid & in_ready;
  assign out_hs     = out_valid_q & out_ready;
  assign first_beat = (state_q == S_IDLE);
  // Tile length is latched on the first beat; a zero count means one channel.
  assign len_eff    = first_beat ? ((num_ch == '0) ? CH_ONE : num_ch) : len_q;
  assign cnt_cur    = first_beat ? '0 : cnt_q;
  assign final_beat = (cnt_cur == len_eff - CH_ONE);

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      prod[k]  = $signed(u_flat[k*in_width +: in_width]) * $signed(v_flat[k*in_width +: in_width]);
      p_ext[k] = DW'(prod[k]);
      // The first beat loads the product directly so no clear cycle is needed.
      sum[k]   = acc_add(first_beat ? '0 : acc_q[k], p_ext[k]);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_valid_d = out_valid_q & ~out_ready;
    for (int k = 0; k < 16; k++) begin
      acc_d[k]  = acc_q[k];
      dout_d[k] = dout_q[k];
    end

    unique case (state_q)
      S_IDLE, S_ACC: begin
        if (fire) begin
          if (first_beat)
            len_d = len_eff;
          if (!final_beat) begin
            for (int k = 0; k < 16; k++)
              acc_d[k] = sum[k];
            cnt_d   = cnt_cur + CH_ONE;
            state_d = S_ACC;
          end else if (!out_valid_q || out_hs) begin
            for (int k = 0; k < 16; k++)
              dout_d[k] = sum[k];
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end else begin
            for (int k = 0; k < 16; k++)
              acc_d[k] = sum[k];
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_hs) begin
          for (int k = 0; k < 16; k++)
            dout_d[k] = acc_q[k];
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        acc_q[k]  <= '0;
        dout_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < 16; k++) begin
        acc_q[k]  <= acc_d[k];
        dout_q[k] <= dout_d[k];
      end
    end
  end

  assign dout0  = dout_q[0];
  assign dout1  = dout_q[1];
  assign dout2  = dout_q[2];
  assign dout3  = dout_q[3];
  assign dout4  = dout_q[4];
  assign dout5  = dout_q[5];
  assign dout6  = dout_q[6];
  assign dout7  = dout_q[7];
  assign dout8  = dout_q[8];
  assign dout9  = dout_q[9];
  assign dout10 = dout_q[10];
  assign dout11 = dout_q[11];
  assign dout12 = dout_q[12];
  assign dout13 = dout_q[13];
  assign dout14 = dout_q[14];
  assign dout15 = dout_q[15];

endmodule

// File: tb/tb_wino_ewmm_acc.sv
// tb/tb_wino_ewmm_acc.sv - directed-vector bench for wino_ewmm_acc
module tb_wino_ewmm_acc;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    num_ch;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  u_flat;
  logic [127:0]  v_flat;
  logic          out_valid;
  logic          out_ready;
  logic [19:0]   d [16];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wino_ewmm_acc dut (
    .clk(clk), .rst_n(rst_n), .num_ch(num_ch),
    .in_valid(in_valid), .in_ready(in_ready),
    .u_flat(u_flat), .v_flat(v_flat),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout0(d[0]),   .dout1(d[1]),   .dout2(d[2]),   .dout3(d[3]),
    .dout4(d[4]),   .dout5(d[5]),   .dout6(d[6]),   .dout7(d[7]),
    .dout8(d[8]),   .dout9(d[9]),   .dout10(d[10]), .dout11(d[11]),
    .dout12(d[12]), .dout13(d[13]), .dout14(d[14]), .dout15(d[15])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_tile(input string tag, input int base, input int stp);
    logic [19:0] e;
    for (int k = 0; k < 16; k++) begin
      e = 20'(base + stp * k);
      chk($sformatf("%s[%0d]", tag, k), 32'(d[k]), 32'(e));
    end
  endtask

  function automatic logic [127:0] pk(input int base, input int stp);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[k*8 +: 8] = 8'(base + stp * k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    num_ch    = 8'd1;
    u_flat    = '0;
    v_flat    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_dout0", 32'(d[0]), 32'd0);
    chk("rst_dout15", 32'(d[15]), 32'd0);
    rst_n = 1'b1;
    step();

    // single channel, 3 * -2
    out_ready = 1'b1;
    num_ch    = 8'd1;
    u_flat    = pk(3, 0);
    v_flat    = pk(-2, 0);
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk_tile("single", -6, 0);
    chk("single_fffa", 32'(d[7]), 32'hFFFFA);
    step();
    chk("single_drain", 32'(out_valid), 32'd0);

    // four channels, u_k = k, v_k = 1
    num_ch   = 8'd4;
    u_flat   = pk(0, 1);
    v_flat   = pk(1, 0);
    in_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      step();
      if (b == 1) num_ch = 8'd2;
      if (b < 3) chk($sformatf("multi_pending%0d", b), 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    chk("multi_valid", 32'(out_valid), 32'd1);
    chk_tile("multi", 0, 4);
    step();
    chk("multi_drain", 32'(out_valid), 32'd0);

    // backpressure: three single-channel tiles with out_ready low
    out_ready = 1'b0;
    num_ch    = 8'd1;
    v_flat    = pk(1, 0);
    u_flat    = pk(1, 0);
    in_valid  = 1'b1;
    step();
    chk("bp_t1_valid", 32'(out_valid), 32'd1);
    chk("bp_t1_ready", 32'(in_ready), 32'd1);
    u_flat = pk(2, 0);
    step();
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_dout", 32'(d[0]), 32'd1);
    u_flat = pk(3, 0);
    step();
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_dout", 32'(d[5]), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_t2_valid", 32'(out_valid), 32'd1);
    chk_tile("bp_t2", 2, 0);
    chk("bp_t2_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_t3_valid", 32'(out_valid), 32'd1);
    chk_tile("bp_t3", 3, 0);
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // overflow: 40 x 127*127
    num_ch   = 8'd40;
    u_flat   = pk(127, 0);
    v_flat   = pk(127, 0);
    in_valid = 1'b1;
    repeat (40) step();
    in_valid = 1'b0;
    chk("ovf_valid", 32'(out_valid), 32'd1);
`ifdef WINO_ACC_SAT_EN
    chk_tile("ovf_sat", 524287, 0);
`else
    chk_tile("ovf_wrap", -403416, 0);
`endif

    // reset mid-tile with a held output
    out_ready = 1'b0;
    num_ch    = 8'd4;
    u_flat    = pk(5, 0);
    v_flat    = pk(5, 0);
    in_valid  = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_dout0", 32'(d[0]), 32'd0);
    chk("mid_rst_dout15", 32'(d[15]), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    num_ch    = 8'd1;
    u_flat    = pk(1, 0);
    v_flat    = pk(1, 0);
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk_tile("post_rst", 1, 0);
    step();

    // num_ch = 0 treated as one channel
    num_ch   = 8'd0;
    u_flat   = pk(2, 0);
    v_flat   = pk(2, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("zero_ch_valid", 32'(out_valid), 32'd1);
    chk_tile("zero_ch", 4, 0);
    step();

    // back-to-back single-channel tiles with out_ready high: no bubble
    num_ch   = 8'd1;
    v_flat   = pk(-1, 0);
    in_valid = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      u_flat = pk(t, 1);
      step();
      chk($sformatf("b2b_valid%0d", t), 32'(out_valid), 32'd1);
      chk($sformatf("b2b_ready%0d", t), 32'(in_ready), 32'd1);
      chk_tile($sformatf("b2b%0d", t), -t, -1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wino_ewmm_acc.md
# wino_ewmm_acc

Element-wise multiply-accumulate stage for the Winograd F(2x2,3x3) datapath. It sits directly upstream of the AT·M·A output transform. Each beat carries one input channel's transformed 4x4 input tile (U) and transformed 4x4 filter tile (V). The block multiplies them element by element, accumulates over `num_ch` channels, and presents the finished 4x4 M tile on `dout0..dout15`, which feed `din0..din15` of the output transform. A double buffer (accumulator plus output register) lets accumulation of the next tile overlap the drain of the previous one.

## Interface
- `data_width`, default 20: width of each accumulated M element and of `dout*`; matches the output transform.
- `in_width`, default 8: signed width of each U/V element.
- `ch_width`, default 8: width of `num_ch`.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `num_ch`  in  ch_width  number of channels per tile; sampled on the first accepted beat of a tile.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accept; a beat transfers when `in_valid & in_ready`.
- `u_flat`  in  16*in_width  U elements; element k at `[k*in_width +: in_width]`, signed.
- `v_flat`  in  16*in_width  V elements; same packing as `u_flat`.
- `out_valid`  out  1  M tile valid.
- `out_ready`  in  1  downstream accept.
- `dout0`..`dout15`  out  data_width each  M tile, row-major 4x4.

## Operation
- Product arithmetic:
  - Per element, `p_k = u_k * v_k` is signed, 2*in_width bits.
  - `p_k` is sign-extended or truncated to data_width.
  - `p_k` is added to `acc_k`, modulo 2^data_width (two's-complement wrap).
- Channel counter `cnt` (ch_width bits) and tile length `len`:
  - On the first beat of a tile, `len = num_ch`; `num_ch = 0` is treated as 1.
  - `num_ch` changes mid-tile are ignored.
  - A beat is final when `cnt == len-1`.
  - The first beat loads `acc_k = p_k`, so there is no separate clear cycle.
- FSM:
  - IDLE: no beat of the current tile accepted yet. `in_ready = 1`.
    - Non-final beat: go to ACC, `cnt = 1`.
    - Final beat: handled by the final-beat rule below.
  - ACC: partial sums held. `in_ready = 1`.
    - Each beat accumulates and increments `cnt`.
    - Final beat: handled by the final-beat rule below.
  - HOLD: a complete tile is in the accumulator and the output register is occupied. `in_ready = 0`.
    - On the output handshake, copy acc to the output register, keep `out_valid = 1`, go to IDLE.
- Final-beat rule: `sum_k = acc_k + p_k` (or `p_k` alone if coming from IDLE).
  - If `out_valid == 0`, or `out_valid & out_ready` in the same cycle: load the output register with `sum`, set `out_valid = 1`, go to IDLE.
  - Otherwise: write `sum` into the accumulator and go to HOLD.
- Output register:
  - `out_valid` clears on handshake unless it is reloaded in the same cycle.
  - `dout*` are stable while `out_valid & !out_ready`.
- Tiles are emitted strictly in completion order; none are dropped or duplicated.

## Timing
- Reset (asynchronous, `rst_n` low):
  - `out_valid = 0`, all `dout* = 0`, FSM = IDLE, `cnt = 0`, accumulator = 0.
  - `in_ready` reads 1 (IDLE); senders hold `in_valid = 0` during reset.
- Reset mid-tile or in HOLD discards partial and held tiles.
- Latency: final beat accepted in cycle t gives `out_valid = 1` with the tile in cycle t+1.
- Throughput: one beat per cycle. A `num_ch = 1` stream with `out_ready` held high yields one tile per cycle.
- Backpressure: at most two complete tiles are buffered (output register plus HOLD). `in_ready` drops the cycle after entering HOLD.
- `in_ready` is a function of state only and has no combinational path from `in_valid` or `out_ready`.

## Configuration
- `WINO_ACC_SAT_EN`
  - Defined: every accumulate (including `sum` on the final beat) saturates to the signed data_width range [-2^(data_width-1), 2^(data_width-1)-1]. Once saturated, later opposite-sign products move the value off the rail normally.
  - Undefined: two's-complement wrap as described in Operation.

## Test plan
All scenarios use defaults (in_width = 8, data_width = 20).
- **Single channel:** `num_ch = 1`, all u = 3, all v = -2, `out_ready = 1` -> next cycle `out_valid = 1`, all `dout = -6` (0xFFFFA); one cycle later `out_valid = 0`.
- **Multi-channel:** `num_ch = 4`, four beats with u_k = k, v_k = 1 -> one tile with `dout_k = 4k` (`dout15 = 60`), one cycle after the 4th beat.
- **Backpressure:**
  - Stimulus: `out_ready = 0`; stream three `num_ch = 1` tiles with all u = 1, 2, 3 and v = 1.
  - After tile 2 completes, `in_ready = 0` and the tile-3 beat stalls.
  - Release `out_ready` -> outputs 1, 2, 3 in order with no loss.
- **Overflow:** `num_ch = 40`, u = v = 127 every beat (true sum 645160) -> wrap build: `dout = -403416`; `WINO_ACC_SAT_EN` build: `dout = 524287`.
- **Reset mid-tile:** `num_ch = 4`, two beats accepted, pulse `rst_n` low -> all outputs 0, `out_valid = 0`; then a `num_ch = 1` tile with u = v = 1 -> `dout = 1` (no residue).
- **Edge cases:**
  - `num_ch = 0` behaves as 1.
  - A final beat arriving in the same cycle as an output handshake loads the new tile with no bubble (`out_valid` stays 1).
